// File: rtl/tomasulo_cdb_arbiter.sv
// Common-data-bus arbiter: per-channel result FIFOs feeding one registered CDB broadcast per cycle.
// Define CDB_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (channel 0 highest).
module tomasulo_cdb_arbiter #(
   parameter int  N_CH      = 4,
   parameter int  DATA_W    = 32,
   parameter int  TAG_W     = 6,
   parameter int  BUF_DEPTH = 2,
   localparam int SRC_W     = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [N_CH-1:0]          ch_valid,
   output logic [N_CH-1:0]          ch_ready,
   input  logic [N_CH*TAG_W-1:0]    ch_tag,
   input  logic [N_CH*DATA_W-1:0]   ch_data,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_data,
   output logic [SRC_W-1:0]         cdb_src
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int ENT_W = TAG_W + DATA_W;

   logic [ENT_W-1:0]  r_mem    [N_CH][BUF_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr [N_CH];
   logic [PTR_W-1:0]  r_rd_ptr [N_CH];
   logic [CNT_W-1:0]  r_count  [N_CH];

   logic              r_cdb_valid;
   logic [TAG_W-1:0]  r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_data;
   logic [SRC_W-1:0]  r_cdb_src;

   logic [N_CH-1:0]   w_ready;
   logic [N_CH-1:0]   w_nonempty;
   logic [N_CH-1:0]   w_push;
   logic [N_CH-1:0]   w_pop;
   logic              w_grant_any;
   logic [SRC_W-1:0]  w_grant_idx;
   logic [ENT_W-1:0]  w_head;

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
      else                            return p + PTR_W'(1);
   endfunction

   // Ready ignores a same-cycle pop, so a full FIFO never accepts; flush drops pushes.
   always_comb begin
      w_ready    = '0;
      w_nonempty = '0;
      w_push     = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_ready[SRC_W'(i)]    = (r_count[SRC_W'(i)] != CNT_W'(BUF_DEPTH));
         w_nonempty[SRC_W'(i)] = (r_count[SRC_W'(i)] != '0);
         w_push[SRC_W'(i)]     = ch_valid[SRC_W'(i)] & w_ready[SRC_W'(i)] & ~flush;
      end
   end

`ifdef CDB_RR_ARB_EN
   logic [SRC_W-1:0] r_rr_ptr;
   logic [SRC_W-1:0] w_rr_next;

   always_comb begin
      int unsigned idx;
      idx         = 0;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      for (int unsigned off = 0; off < N_CH; off++) begin
         idx = 32'(r_rr_ptr) + off;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!w_grant_any && w_nonempty[SRC_W'(idx)]) begin
            w_grant_any = 1'b1;
            w_grant_idx = SRC_W'(idx);
         end
      end
      w_rr_next = (w_grant_idx == SRC_W'(N_CH - 1)) ? '0 : w_grant_idx + SRC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_rr_ptr <= '0;
      else if (!flush && w_grant_any)  r_rr_ptr <= w_rr_next;
   end
`else
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!w_grant_any && w_nonempty[SRC_W'(i)]) begin
            w_grant_any = 1'b1;
            w_grant_idx = SRC_W'(i);
         end
      end
   end
`endif

   always_comb begin
      w_pop = '0;
      if (w_grant_any && !flush) w_pop[w_grant_idx] = 1'b1;
   end

   assign w_head = r_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (w_push[SRC_W'(i)])
            r_mem[SRC_W'(i)][r_wr_ptr[SRC_W'(i)]] <= {ch_tag[i*TAG_W +: TAG_W], ch_data[i*DATA_W +: DATA_W]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            r_wr_ptr[SRC_W'(i)] <= '0;
            r_rd_ptr[SRC_W'(i)] <= '0;
            r_count[SRC_W'(i)]  <= '0;
         end
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
         r_cdb_src   <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            r_wr_ptr[SRC_W'(i)] <= '0;
            r_rd_ptr[SRC_W'(i)] <= '0;
            r_count[SRC_W'(i)]  <= '0;
         end
         r_cdb_valid <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_push[SRC_W'(i)]) r_wr_ptr[SRC_W'(i)] <= f_ptr_inc(r_wr_ptr[SRC_W'(i)]);
            if (w_pop[SRC_W'(i)])  r_rd_ptr[SRC_W'(i)] <= f_ptr_inc(r_rd_ptr[SRC_W'(i)]);
            case ({w_push[SRC_W'(i)], w_pop[SRC_W'(i)]})
               2'b10:   r_count[SRC_W'(i)] <= r_count[SRC_W'(i)] + CNT_W'(1);
               2'b01:   r_count[SRC_W'(i)] <= r_count[SRC_W'(i)] - CNT_W'(1);
               default: ;
            endcase
         end
         r_cdb_valid <= w_grant_any;
         if (w_grant_any) begin
            r_cdb_tag  <= w_head[ENT_W-1 -: TAG_W];
            r_cdb_data <= w_head[DATA_W-1:0];
            r_cdb_src  <= w_grant_idx;
         end
      end
   end

   assign ch_ready  = w_ready;
   assign cdb_valid = r_cdb_valid;
   assign cdb_tag   = r_cdb_tag;
   assign cdb_data  = r_cdb_data;
   assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_tomasulo_cdb_arbiter.sv
// Self-checking bench for tomasulo_cdb_arbiter: per-channel-ordered scoreboard plus scenario checks.
module tb_tomasulo_cdb_arbiter;
   localparam int N_CH      = 4;
   localparam int DATA_W    = 32;
   localparam int TAG_W     = 6;
   localparam int BUF_DEPTH = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [3:0]   ch_valid;
   logic [3:0]   ch_ready;
   logic [23:0]  ch_tag;
   logic [127:0] ch_data;
   logic         cdb_valid;
   logic [5:0]   cdb_tag;
   logic [31:0]  cdb_data;
   logic [1:0]   cdb_src;

   tomasulo_cdb_arbiter #(
      .N_CH(N_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_tag(ch_tag), .ch_data(ch_data),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic [5:0]  tag;
      logic [31:0] data;
   } sb_t;

   sb_t         sb_q[$];
   int          checks = 0;
   int          passed = 0;
   logic        o_valid;
   logic [1:0]  o_src;
   logic [5:0]  o_tag;
   logic [31:0] o_data;

   // One clock: check ready against the model, drive, clock, then score the CDB.
   task automatic tick(input logic [3:0] v, input logic [23:0] tg, input logic [127:0] dt,
                       input logic fl, output logic [3:0] acc);
      int pending;
      int occ;
      int hit;
      logic [3:0] exp_rdy;
      pending = sb_q.size();
      for (int i = 0; i < 4; i++) begin
         occ = 0;
         foreach (sb_q[j]) if (sb_q[j].src == 2'(i)) occ++;
         exp_rdy[i] = (occ < BUF_DEPTH);
      end
      checks++;
      if (ch_ready !== exp_rdy) $display("FAIL ch_ready: got %b expected %b", ch_ready, exp_rdy);
      else passed++;
      acc = fl ? 4'b0000 : (v & exp_rdy);
      ch_valid = v;
      ch_tag   = tg;
      ch_data  = dt;
      flush    = fl;
      for (int i = 0; i < 4; i++)
         if (acc[i]) sb_q.push_back('{2'(i), tg[i*6 +: 6], dt[i*32 +: 32]});
      @(posedge clk);
      #1;
      ch_valid = '0;
      flush    = 1'b0;
      o_valid  = cdb_valid;
      o_src    = cdb_src;
      o_tag    = cdb_tag;
      o_data   = cdb_data;
      checks++;
      if (fl) begin
         sb_q.delete();
         if (cdb_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", cdb_valid);
         else passed++;
      end else if (pending == 0) begin
         if (cdb_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", cdb_valid);
         else passed++;
      end else if (cdb_valid !== 1'b1) begin
         $display("FAIL grant_valid: got %b expected 1 (%0d pending)", cdb_valid, pending);
      end else begin
         hit = -1;
         for (int j = 0; j < pending; j++)
            if (hit < 0 && sb_q[j].src == cdb_src) hit = j;
         if (hit < 0)
            $display("FAIL cdb_src: got %0d with no pending entry for that channel", cdb_src);
         else if (cdb_tag !== sb_q[hit].tag || cdb_data !== sb_q[hit].data)
            $display("FAIL cdb_entry ch%0d: got tag %h data %h expected tag %h data %h",
                     cdb_src, cdb_tag, cdb_data, sb_q[hit].tag, sb_q[hit].data);
         else passed++;
         if (hit >= 0) sb_q.delete(hit);
      end
   endtask

   task automatic do_reset();
      ch_valid = '0;
      flush    = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      logic [3:0] acc;
      #2;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 6'h0 || cdb_data !== 32'h0 || cdb_src !== 2'd0)
         $display("FAIL reset_outputs: got v=%b tag=%h data=%h src=%0d expected all 0",
                  cdb_valid, cdb_tag, cdb_data, cdb_src);
      else passed++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (ch_ready !== 4'b1111) $display("FAIL reset_ready: got %b expected 1111", ch_ready);
      else passed++;
      tick(4'b1111, {6'h14, 6'h13, 6'h12, 6'h11},
           {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, 1'b0, acc);
      tick(4'b0000, '0, '0, 1'b0, acc);
      rst = 1'b1;
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== 6'h0 || cdb_data !== 32'h0)
         $display("FAIL midreset_outputs: got v=%b tag=%h data=%h expected all 0",
                  cdb_valid, cdb_tag, cdb_data);
      else passed++;
      sb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (ch_ready !== 4'b1111) $display("FAIL midreset_ready: got %b expected 1111", ch_ready);
      else passed++;
      tick(4'b0000, '0, '0, 1'b0, acc);
   endtask

   task automatic test_single();
      logic [3:0] acc;
      do_reset();
      tick(4'b0010, {6'h0, 6'h0, 6'h05, 6'h0}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 1'b0, acc);
      tick(4'b0000, '0, '0, 1'b0, acc);
      checks++;
      if (o_valid !== 1'b1 || o_src !== 2'd1 || o_tag !== 6'h05 || o_data !== 32'hDEADBEEF)
         $display("FAIL single: got v=%b src=%0d tag=%h data=%h expected 1/1/05/deadbeef",
                  o_valid, o_src, o_tag, o_data);
      else passed++;
      tick(4'b0000, '0, '0, 1'b0, acc);
      checks++;
      if (o_valid !== 1'b0 || o_tag !== 6'h05 || o_data !== 32'hDEADBEEF)
         $display("FAIL single_hold: got v=%b tag=%h data=%h expected 0/05/deadbeef",
                  o_valid, o_tag, o_data);
      else passed++;
   endtask

   task automatic test_contention();
      logic [3:0] acc;
      do_reset();
      tick(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},
           {32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001}, 1'b0, acc);
      for (int k = 1; k <= 4; k++) begin
         tick(4'b0000, '0, '0, 1'b0, acc);
         checks++;
         if (o_valid !== 1'b1 || o_tag !== 6'(k))
            $display("FAIL contention_order[%0d]: got v=%b tag=%0d expected tag %0d", k, o_valid, o_tag, k);
         else passed++;
      end
      tick(4'b0000, '0, '0, 1'b0, acc);
   endtask

   task automatic test_fairness();
      logic [3:0] acc;
      int seen_at;
      seen_at = 0;
      do_reset();
      tick(4'b1001, {6'h33, 6'h0, 6'h0, 6'h20}, {32'h3333_3333, 64'h0, 32'h0000_0020}, 1'b0, acc);
      for (int k = 1; k <= 8; k++) begin
         tick(4'b0001, {18'h0, 6'(k)}, {96'h0, 32'(k)}, 1'b0, acc);
         if (seen_at == 0 && o_valid && o_src == 2'd3) seen_at = k + 1;
      end
`ifdef CDB_RR_ARB_EN
      checks++;
      if (seen_at == 0 || seen_at > 4)
         $display("FAIL fairness_rr: ch3 broadcast at cycle %0d expected 1..4", seen_at);
      else passed++;
`else
      checks++;
      if (seen_at != 0)
         $display("FAIL fairness_fixed: ch3 broadcast at cycle %0d expected starvation", seen_at);
      else passed++;
`endif
      for (int k = 1; k <= 4; k++) begin
         tick(4'b0000, '0, '0, 1'b0, acc);
         if (seen_at == 0 && o_valid && o_src == 2'd3) seen_at = 100 + k;
      end
      checks++;
      if (seen_at == 0) $display("FAIL fairness_drain: ch3 never broadcast expected within 4 idle cycles");
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [3:0]  acc;
      logic [5:0]  exp_tag[3];
      logic [5:0]  rec[3];
      int          idx;
      int          nrec;
      logic [3:0]  v;
      exp_tag = '{6'h2A, 6'h2B, 6'h2C};
      idx  = 0;
      nrec = 0;
      do_reset();
      for (int n = 0; n < 30; n++) begin
         v = 4'b0000;
         if (n < 6) v[0] = 1'b1;
         if (idx < 3) v[2] = 1'b1;
         tick(v, {6'h0, exp_tag[idx < 3 ? idx : 2], 6'h0, 6'(n)},
              {32'h0, 32'hA000_0000 + 32'(idx), 32'h0, 32'(n)}, 1'b0, acc);
         if (acc[2]) begin
            idx++;
            if (idx == 2) begin
               checks++;
               if (ch_ready[2] !== 1'b0) $display("FAIL full_ready: got %b expected 0", ch_ready[2]);
               else passed++;
            end
         end
         if (o_valid && o_src == 2'd2 && nrec < 3) begin
            rec[nrec] = o_tag;
            nrec++;
         end
`ifndef CDB_RR_ARB_EN
         if (n == 5) begin
            checks++;
            if (idx !== 2) $display("FAIL held_third: got %0d accepted expected 2", idx);
            else passed++;
         end
`endif
         if (nrec == 3 && sb_q.size() == 0) break;
      end
      checks++;
      if (nrec != 3) $display("FAIL bp_timeout: got %0d ch2 broadcasts expected 3", nrec);
      else passed++;
      for (int k = 0; k < nrec; k++) begin
         checks++;
         if (rec[k] !== exp_tag[k]) $display("FAIL bp_order[%0d]: got %h expected %h", k, rec[k], exp_tag[k]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] acc;
      int nv;
      nv = 0;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         tick(4'b0010, {12'h0, 6'(8 + k), 6'h0}, {32'h0, 32'h0, 32'hB0B0_0000 + 32'(k), 32'h0}, 1'b0, acc);
         if (o_valid) nv++;
      end
      tick(4'b0000, '0, '0, 1'b0, acc);
      if (o_valid) nv++;
      checks++;
      if (nv != 6) $display("FAIL b2b_count: got %0d broadcasts expected 6", nv);
      else passed++;
   endtask

   task automatic test_flush();
      logic [3:0] acc;
      do_reset();
      for (int k = 0; k < 3; k++)
         tick(4'b0011, {12'h0, 6'(16 + k), 6'(k)}, {64'h0, 32'h1100_0000 + 32'(k), 32'h0000_0000 + 32'(k)}, 1'b0, acc);
      tick(4'b0100, {6'h0, 6'h3F, 12'h0}, {32'h0, 32'hFEED_F00D, 64'h0}, 1'b1, acc);
      checks++;
      if (ch_ready !== 4'b1111) $display("FAIL flush_ready: got %b expected 1111", ch_ready);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         tick(4'b0000, '0, '0, 1'b0, acc);
         checks++;
         if (o_valid !== 1'b0) $display("FAIL flush_drop[%0d]: got valid %b tag %h expected 0", k, o_valid, o_tag);
         else passed++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      ch_valid = '0;
      ch_tag   = '0;
      ch_data  = '0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_back_to_back();
      test_flush();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
